// File: rtl/cpu_data_ram.sv
// cpu_data_ram: 64x16 CPU data memory with a power-up init sweep, a shared tristate bus,
// a sticky read/write collision flag and a combinational debug read port.
module cpu_data_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 64,
  parameter int INIT_MODE  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_to_ram,
  input  logic                  write_enable_to_ram,
  input  logic                  read_enable_to_ram,
  input  logic                  enable_ram_read,
  inout  wire  [DATA_WIDTH-1:0] data_ram,
  output logic                  ram_ready,
  output logic                  collision_err,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);
  typedef enum logic {INIT, RUN} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_ptr_q, init_ptr_d;
  logic                  ready_q, ready_d;
  logic                  coll_q, coll_d;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  run, last, drive;
  assign run   = state_q == RUN;
  assign last  = init_ptr_q == ADDR_WIDTH'(DEPTH - 1);
  assign drive = run && read_enable_to_ram && enable_ram_read && !write_enable_to_ram;
  assign data_ram      = drive ? mem[address_to_ram] : 'z;
  assign dbg_data      = mem[dbg_addr];
  assign ram_ready     = ready_q;
  assign collision_err = coll_q;
  always_comb begin
    state_d    = (!run && last) ? RUN : state_q;
    init_ptr_d = run ? init_ptr_q : init_ptr_q + 1'b1;
    ready_d    = ready_q || (!run && last);
    coll_d     = coll_q || (run && write_enable_to_ram && read_enable_to_ram);
    // reset blocks every memory write, including a CPU write in the same cycle
    mem_we     = !reset && (run ? write_enable_to_ram && !read_enable_to_ram : 1'b1);
    mem_wa     = run ? address_to_ram : init_ptr_q;
    mem_wd     = run ? data_ram : (INIT_MODE != 0 ? DATA_WIDTH'(init_ptr_q) << 1 : '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
      ready_q    <= 1'b0;
      coll_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      ready_q    <= ready_d;
      coll_q     <= coll_d;
    end
  end
  always_ff @(posedge clk)
    if (mem_we) mem[mem_wa] <= mem_wd;
endmodule

// File: tb/tb_cpu_data_ram.sv
// tb_cpu_data_ram: randomized self-checking bench for cpu_data_ram against an array model.
module tb_cpu_data_ram;
  logic        clk = 0, reset = 1;
  logic [5:0]  addr = 0, dbg_addr = 0;
  logic        we = 0, re = 0, ere = 0;
  logic [15:0] bus_drv = 0;
  logic        bus_oe = 0;
  tri0  [15:0] data_ram;
  wire         ram_ready, collision_err;
  wire  [15:0] dbg_data;
  int          checks = 0, errors = 0;
  logic [15:0] model [64];

  assign data_ram = bus_oe ? bus_drv : 'z;
  always #5 clk = ~clk;

  cpu_data_ram dut (
    .clk(clk), .reset(reset), .address_to_ram(addr), .write_enable_to_ram(we),
    .read_enable_to_ram(re), .enable_ram_read(ere), .data_ram(data_ram),
    .ram_ready(ram_ready), .collision_err(collision_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] pat(input int i);
    return 16'(2 * i);
  endfunction

  task automatic test_reset;
    reset = 1; addr = 3; re = 1; ere = 1;
    tick(7);
    checks++; if (ram_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ram_ready); end
    checks++; if (collision_err !== 1'b0) begin errors++; $display("FAIL reset_coll: got %b expected 0", collision_err); end
    checks++; if (data_ram !== 16'h0000) begin errors++; $display("FAIL reset_bus_z: got %h expected undriven", data_ram); end
    re = 0; ere = 0;
  endtask

  task automatic test_init_sweep;
    int rose = 0;
    reset = 0;
    for (int e = 1; e <= 100 && rose == 0; e++) begin
      tick();
      if (ram_ready === 1'b1) rose = e;
    end
    checks++; if (rose != 64) begin errors++; $display("FAIL init_ready_edge: got %0d expected 64", rose); end
    for (int i = 0; i < 64; i++) model[i] = pat(i);
    foreach (model[i]) begin
      dbg_addr = (i < 3) ? 6'((i == 0) ? 0 : (i == 1) ? 5 : 63) : 6'($urandom_range(0, 63));
      #0.1;
      checks++; if (dbg_data !== model[dbg_addr]) begin errors++; $display("FAIL init_dbg[%0d]: got %h expected %h", dbg_addr, dbg_data, model[dbg_addr]); end
    end
    tick();
  endtask

  task automatic test_read;
    addr = 3; re = 1; ere = 1; #1;
    checks++; if (data_ram !== model[3]) begin errors++; $display("FAIL read_addr3: got %h expected %h", data_ram, model[3]); end
    ere = 0; #1;
    checks++; if (data_ram !== 16'h0000) begin errors++; $display("FAIL read_gate_off: got %h expected undriven", data_ram); end
    ere = 1;
    for (int r = 0; r < 2; r++) begin
      tick();
      for (int k = 0; k < 7; k++) begin
        addr = 6'($urandom_range(1, 63)); #1;
        checks++; if (data_ram !== model[addr]) begin errors++; $display("FAIL read_rand[%0d]: got %h expected %h", addr, data_ram, model[addr]); end
      end
    end
    re = 0; ere = 0;
    tick();
  endtask

  task automatic test_write;
    addr = 6'h2A; bus_drv = 16'hBEEF; bus_oe = 1; we = 1;
    tick();
    model[6'h2A] = 16'hBEEF;
    we = 0; bus_oe = 0; dbg_addr = 6'h2A; #1;
    checks++; if (dbg_data !== 16'hBEEF) begin errors++; $display("FAIL write_dbg: got %h expected beef", dbg_data); end
    re = 1; ere = 1; #1;
    checks++; if (data_ram !== 16'hBEEF) begin errors++; $display("FAIL write_readback: got %h expected beef", data_ram); end
    addr = 6'h2B; #1;
    checks++; if (data_ram !== model[6'h2B]) begin errors++; $display("FAIL write_neighbour: got %h expected %h", data_ram, model[6'h2B]); end
    re = 0; ere = 0;
    tick();
  endtask

  task automatic test_back_to_back;
    logic [5:0] a, other;
    for (int n = 0; n < 20; n++) begin
      do a = 6'($urandom_range(0, 63)); while (a == 4 || a == 10 || a == 60 || a == 6'h2A);
      addr = a; bus_drv = 16'($urandom); bus_oe = 1; we = 1; re = 0; ere = 1'($urandom);
      tick();
      model[a] = bus_drv;
      we = 0; bus_oe = 0; re = 1; ere = 1; #1;
      checks++; if (data_ram !== model[a]) begin errors++; $display("FAIL b2b_read[%0d]: got %h expected %h", a, data_ram, model[a]); end
      other = 6'($urandom_range(0, 63)); dbg_addr = other; #1;
      checks++; if (dbg_data !== model[other]) begin errors++; $display("FAIL b2b_dbg[%0d]: got %h expected %h", other, dbg_data, model[other]); end
      re = 0; ere = 0;
    end
    tick();
  endtask

  task automatic test_collision;
    addr = 4; bus_drv = 16'h1234; bus_oe = 1; we = 1; re = 1; ere = 1; #1;
    checks++; if (data_ram !== 16'h1234) begin errors++; $display("FAIL coll_bus_pre: got %h expected 1234", data_ram); end
    tick();
    checks++; if (collision_err !== 1'b1) begin errors++; $display("FAIL coll_flag: got %b expected 1", collision_err); end
    bus_oe = 0; dbg_addr = 4; #1;
    checks++; if (data_ram !== 16'h0000) begin errors++; $display("FAIL coll_bus_z: got %h expected undriven", data_ram); end
    checks++; if (dbg_data !== model[4]) begin errors++; $display("FAIL coll_mem4: got %h expected %h", dbg_data, model[4]); end
    we = 0; re = 0; ere = 0;
    tick(10);
    checks++; if (collision_err !== 1'b1) begin errors++; $display("FAIL coll_sticky: got %b expected 1", collision_err); end
  endtask

  task automatic test_reset_mid_init;
    int rose = 0;
    reset = 1; addr = 7; bus_drv = 16'hAAAA; bus_oe = 1; we = 1;
    tick();
    dbg_addr = 7; #1;
    checks++; if (dbg_data !== model[7]) begin errors++; $display("FAIL reset_wins_write: got %h expected %h", dbg_data, model[7]); end
    we = 0; bus_oe = 0; reset = 0;
    tick(20);
    for (int i = 0; i < 20; i++) model[i] = pat(i);
    reset = 1;
    tick(2);
    checks++; if (collision_err !== 1'b0) begin errors++; $display("FAIL mid_reset_coll: got %b expected 0", collision_err); end
    dbg_addr = 6'h2A; #1;
    checks++; if (dbg_data !== model[6'h2A]) begin errors++; $display("FAIL mid_reset_keep: got %h expected %h", dbg_data, model[6'h2A]); end
    reset = 0;
    for (int e = 1; e <= 100 && rose == 0; e++) begin
      if (e == 30) begin addr = 3; re = 1; ere = 1; #1;
        checks++; if (data_ram !== 16'h0000) begin errors++; $display("FAIL init_bus_z: got %h expected undriven", data_ram); end
      end
      if (e == 31) begin re = 0; ere = 0; end
      if (e == 40) begin we = 1; re = 1; end
      if (e == 41) begin we = 0; re = 0; end
      if (e == 62) begin addr = 60; bus_drv = 16'hFFFF; bus_oe = 1; we = 1; end
      if (e == 64) begin we = 0; bus_oe = 0; end
      tick();
      if (ram_ready === 1'b1) rose = e;
    end
    checks++; if (rose != 64) begin errors++; $display("FAIL mid_ready_edge: got %0d expected 64", rose); end
    checks++; if (collision_err !== 1'b0) begin errors++; $display("FAIL init_coll_ignored: got %b expected 0", collision_err); end
    we = 0; bus_oe = 0;
    for (int i = 0; i < 64; i++) model[i] = pat(i);
    addr = 60; re = 1; ere = 1; #1;
    checks++; if (data_ram !== 16'h0078) begin errors++; $display("FAIL init_write_ignored: got %h expected 0078", data_ram); end
    re = 0; ere = 0;
    for (int i = 0; i < 64; i++) begin
      dbg_addr = 6'(i); #0.1;
      checks++; if (dbg_data !== model[i]) begin errors++; $display("FAIL reinit_dbg[%0d]: got %h expected %h", i, dbg_data, model[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_read();
    test_write();
    test_back_to_back();
    test_collision();
    test_reset_mid_init();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_data_ram.md
Name: cpu_data_ram

Overview:
- 64x16 data memory attached directly to the CPU's RAM port.
- Consumes the CPU's address, write-enable, read-enable and read-gate strobes, and shares the CPU's bidirectional 16-bit data bus.
- After reset it runs a self-initialisation sweep that loads a known pattern.
- While serving the CPU it reports bus-direction collisions.
- Provides a side debug read port for the bench.

Parameters:
- DATA_WIDTH, 16, word width of the data bus and storage.
- ADDR_WIDTH, 6, address width.
- DEPTH, 64, number of words; must equal 2**ADDR_WIDTH.
- INIT_MODE, 1, init pattern: 0 = all zeros; 1 = word i holds 2*i, truncated to DATA_WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- address_to_ram  in  ADDR_WIDTH  word address from the CPU.
- write_enable_to_ram  in  1  CPU write strobe.
- read_enable_to_ram  in  1  CPU read strobe.
- enable_ram_read  in  1  CPU read gate; a read drives the bus only while this is high.
- data_ram  inout  DATA_WIDTH  shared data bus; the CPU drives it on writes, this block drives it on reads, otherwise Z.
- ram_ready  out  1  high once initialisation is complete.
- collision_err  out  1  sticky flag: read and write were requested in the same cycle.
- dbg_addr  in  ADDR_WIDTH  debug read address.
- dbg_data  out  DATA_WIDTH  combinational mem[dbg_addr]; valid in any state.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high: sampled on the rising clk edge, no asynchronous path.
- Reset values: state=INIT, init_ptr=0, ram_ready=0, collision_err=0, data_ram=Z. Memory contents are not modified while reset is high.
- States:
  - INIT -> RUN: after the final init write.
  - RUN -> INIT: only via reset.
- INIT: each edge with reset low writes mem[init_ptr]=pattern(init_ptr) and increments init_ptr.
  - The write at init_ptr==DEPTH-1 also sets state=RUN and ram_ready=1.
  - ram_ready therefore rises on the DEPTH-th edge (64th by default) after the first edge that samples reset low.
- INIT bus handling: CPU writes are ignored, data_ram stays Z, collision_err is not updated.
- Reset mid-INIT: the sweep restarts from address 0. Words already written keep their values until overwritten.
- RUN read: when read_enable_to_ram=1, enable_ram_read=1 and write_enable_to_ram=0, data_ram = mem[address_to_ram].
  - This is an asynchronous (combinational) read with zero-cycle latency, and it follows address changes within the cycle.
  - Otherwise data_ram=Z.
- RUN write: when write_enable_to_ram=1 and read_enable_to_ram=0, the rising edge stores data_ram into mem[address_to_ram]. enable_ram_read does not gate writes.
- RUN collision: when write_enable_to_ram=1 and read_enable_to_ram=1, no write, bus stays Z, and collision_err is set at the edge. It stays 1 until reset.
- Write-then-read: a read in the cycle after a write to the same address returns the new value. The debug port reflects a write immediately after the edge.
- Address wrap: none needed, since DEPTH=2**ADDR_WIDTH and every address is valid.
- Simultaneous reset and write: reset wins, and the write is discarded.
- Block never drives data_ram while write_enable_to_ram=1, in any state.

Test Plan:
- Init sweep: pulse reset for 7 cycles then release -> ram_ready=0 for 63 edges and 1 after the 64th; dbg_addr=0/5/63 read 0x0000/0x000A/0x007E.
- Read: in RUN, addr=3, read_enable=1, enable_ram_read=1 -> data_ram=0x0006 in the same cycle. Drop enable_ram_read -> data_ram=Z.
- Write/readback: bench drives 0xBEEF at addr=0x2A with write_enable=1 for one edge, then reads addr 0x2A -> 0xBEEF. Addr 0x2B still reads 0x0056.
- Collision: write_enable=1 and read_enable=1 at addr=4 with bus=0x1234 -> collision_err=1 after the edge, mem[4] stays 0x0008, data_ram not driven by the block. The flag stays set through 10 idle cycles and clears only on reset.
- Reset mid-init: assert reset 20 cycles into INIT, then release -> ram_ready rises 64 edges after release; word 10 reads 0x0014.
- Writes during INIT: write 0xFFFF to addr 60 while ram_ready=0 -> ignored, and addr 60 reads 0x0078 after init completes.
